conv_row_scheduler: RTL and testbench
=====================================

Name: conv_row_scheduler

Overview:
- Sequences the 6-wide convolution kernel array over one 8x8 image with a 3x3 kernel at stride 1, producing 6 output rows of 6 features each.
- Per output row, issues 9 taps to the input interface and weight cache. Each tap carries a pixel row, a starting pixel column and a weight address.
- Waits for the MAC pipeline to drain, then hands the finished row to the output stage over a valid/ready handshake.
- Sits between the layer controller (start/abort/done) and the input interface, weight cache and kernel array.

Parameters:
- KERNEL_SIZE, 3, kernel edge length.
- IMAGE_SIZE, 8, input image edge length.
- ARRAY_SIZE, 6, number of parallel kernels; must equal IMAGE_SIZE-KERNEL_SIZE+1 (elaboration error otherwise).
- PIPE_LAT, 4, cycles from the last tap transfer until the array's accumulators are final; range 1..15.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one image; sampled only in IDLE.
- abort  in  1  synchronous abandon of the current image.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.
- tap_valid  out  1  tap fields valid.
- tap_ready  in  1  input interface and weight cache accept the tap.
- pix_row  out  $clog2(IMAGE_SIZE)  image row = r+kr.
- pix_col  out  $clog2(IMAGE_SIZE)  starting column = kc; the array reads columns kc..kc+ARRAY_SIZE-1.
- w_addr  out  $clog2(KERNEL_SIZE*KERNEL_SIZE)  weight index = kr*KERNEL_SIZE+kc.
- tap_first  out  1  qualifies the tap (kr=0,kc=0); the array clears its accumulators.
- tap_last  out  1  qualifies the tap (kr=K-1,kc=K-1).
- row_valid  out  1  the array's outputs hold output row row_idx.
- row_ready  in  1  output stage accepts the row.
- row_idx  out  $clog2(ARRAY_SIZE)  current output row r.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, tap_valid=0, row_valid=0, tap_first=0, tap_last=0, pix_row=0, pix_col=0, w_addr=0, row_idx=0, all counters 0. A reset mid-operation takes effect at the next edge and no done is produced.
- States are IDLE, ISSUE, DRAIN, EMIT, DONE.
- IDLE: start=1 with abort=0 loads r=kr=kc=0, next state ISSUE.
- ISSUE: tap_valid=1. Outputs are registered and change only on a transfer (tap_valid & tap_ready).
  - While tap_ready=0, all tap fields hold stable.
  - Tap order: kr outer, kc inner.
  - On transfer of the last tap, load drain_cnt=PIPE_LAT-1 and go to DRAIN; tap_valid drops.
- DRAIN: stays exactly PIPE_LAT cycles, decrementing drain_cnt; at 0 go to EMIT.
- EMIT: row_valid=1, row_idx=r, held until row_ready.
  - On accept with r<ARRAY_SIZE-1: r+1, kr=kc=0, go to ISSUE.
  - On accept with r=ARRAY_SIZE-1: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Unloaded timing: start sampled at edge 0; row n issue cycles are 14n+1..14n+9, drain 14n+10..14n+13, emit 14n+14; done asserted in cycle 85.
- start while not IDLE is ignored.
- abort in any non-IDLE state: next state IDLE, all handshake outputs low, no done. abort in IDLE overrides start.
- No tap is ever skipped or duplicated; tap_valid and row_valid are never high together.

Decomposition:
- Package conv_sched_pkg holds:
  - state enum sched_state_t;
  - derived widths PIX_W, WADDR_W, ROW_W, DRAIN_W;
  - constants TAPS_PER_ROW=KERNEL_SIZE*KERNEL_SIZE and OUT_SIZE.
- Sub-module conv_tap_counter: nested kr/kc counter with clear and advance inputs. It outputs kr, kc, w_addr, first and last. The top holds the FSM, the r counter and the drain counter.

Test Plan:
- Reset, then start pulse with tap_ready=row_ready=1: cycle 1 has pix_row=0, pix_col=0, w_addr=0, tap_first=1; cycle 9 has pix_row=2, pix_col=2, w_addr=8, tap_last=1; row_valid with row_idx=0 at cycle 14; row 5 at cycle 84; done pulse at cycle 85; busy high for cycles 1..85; 54 taps in total.
- Drop tap_ready for 3 cycles while tap 4 of row 1 is presented: pix_row=2, pix_col=1, w_addr=4 held; sequence resumes with no gap or duplicate; done arrives at cycle 88.
- Hold row_ready=0 for 5 cycles in EMIT of row 2: row_valid=1 and row_idx=2 stable, tap_valid=0; row 3 tap_first appears the cycle after acceptance.
- Assert start during ISSUE of row 1: no effect. Assert start and abort together in IDLE: remains IDLE, busy=0.
- Assert abort during DRAIN of row 3: IDLE next cycle, tap_valid=row_valid=0, no done. A following start restarts at pix_row=0, row_idx=0.
- Assert rst mid-ISSUE: all outputs at reset values next cycle. Rerun with PIPE_LAT=1: row_valid exactly 1 cycle after each tap_last transfer, done at cycle 67.

Source files
------------

// File: rtl/conv_row_scheduler_pkg.sv
// Shared geometry, derived widths and FSM state type for the convolution row scheduler.
package conv_sched_pkg;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int IMAGE_SIZE_DEF  = 8;
  localparam int ARRAY_SIZE_DEF  = IMAGE_SIZE_DEF - KERNEL_SIZE_DEF + 1;

  localparam int TAPS_PER_ROW = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int OUT_SIZE     = ARRAY_SIZE_DEF;

  localparam int PIX_W   = $clog2(IMAGE_SIZE_DEF);
  localparam int WADDR_W = $clog2(TAPS_PER_ROW);
  localparam int ROW_W   = $clog2(OUT_SIZE);
  localparam int KIDX_W  = $clog2(KERNEL_SIZE_DEF);
  // Sized for the largest supported PIPE_LAT (15).
  localparam int DRAIN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;
endpackage

// File: rtl/conv_row_scheduler_if.sv
// Control, tap and row handshakes between the scheduler and its neighbours.
interface conv_row_scheduler_if import conv_sched_pkg::*;;
  logic               start, abort, busy, done;
  logic               tap_valid, tap_ready, tap_first, tap_last;
  logic [PIX_W-1:0]   pix_row, pix_col;
  logic [WADDR_W-1:0] w_addr;
  logic               row_valid, row_ready;
  logic [ROW_W-1:0]   row_idx;

  modport master (
    input  start, abort, tap_ready, row_ready,
    output busy, done, tap_valid, tap_first, tap_last, pix_row, pix_col,
           w_addr, row_valid, row_idx
  );
  modport slave (
    output start, abort, tap_ready, row_ready,
    input  busy, done, tap_valid, tap_first, tap_last, pix_row, pix_col,
           w_addr, row_valid, row_idx
  );
endinterface

// File: rtl/conv_row_scheduler_tap_counter.sv
// Nested kernel-row / kernel-column tap counter; wraps to (0,0) after the last tap.
module conv_tap_counter import conv_sched_pkg::*; #(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_adv,
  output logic [KIDX_W-1:0]  o_kr,
  output logic [KIDX_W-1:0]  o_kc,
  output logic [WADDR_W-1:0] o_w_addr,
  output logic               o_first,
  output logic               o_last
);
  logic [KIDX_W-1:0]  r_kr, r_kc;
  logic [WADDR_W-1:0] r_w;
  logic               w_kc_end, w_kr_end;

  assign w_kc_end = (r_kc == KIDX_W'(KERNEL_SIZE - 1));
  assign w_kr_end = (r_kr == KIDX_W'(KERNEL_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_kr <= '0;
      r_kc <= '0;
      r_w  <= '0;
    end else if (i_adv) begin
      r_w <= o_last ? '0 : r_w + WADDR_W'(1);
      if (w_kc_end) begin
        r_kc <= '0;
        r_kr <= w_kr_end ? '0 : r_kr + KIDX_W'(1);
      end else begin
        r_kc <= r_kc + KIDX_W'(1);
      end
    end
  end

  assign o_kr     = r_kr;
  assign o_kc     = r_kc;
  assign o_w_addr = r_w;
  assign o_first  = (r_kr == '0) && (r_kc == '0);
  assign o_last   = w_kr_end && w_kc_end;
endmodule

// File: rtl/conv_row_scheduler.sv
// Walks one image row by row: 9 taps per output row, pipeline drain, then row handoff.
module conv_row_scheduler import conv_sched_pkg::*; #(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF,
  parameter int ARRAY_SIZE  = ARRAY_SIZE_DEF,
  parameter int PIPE_LAT    = 4
) (
  input logic                  clk,
  input logic                  rst,
  conv_row_scheduler_if.master bus
);
  if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_bad_geom
    $error("ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
  end
  if (PIPE_LAT < 1 || PIPE_LAT > 15) begin : g_bad_lat
    $error("PIPE_LAT must be in 1..15");
  end
  if ($clog2(IMAGE_SIZE) > PIX_W || $clog2(ARRAY_SIZE) > ROW_W ||
      $clog2(KERNEL_SIZE) > KIDX_W || $clog2(KERNEL_SIZE * KERNEL_SIZE) > WADDR_W) begin : g_bad_w
    $error("geometry exceeds package field widths");
  end

  sched_state_t       r_state;
  logic [ROW_W-1:0]   r_row;
  logic [DRAIN_W-1:0] r_drain;
  logic [KIDX_W-1:0]  w_kr, w_kc;
  logic [WADDR_W-1:0] w_waddr;
  logic               w_first, w_last, w_abort, w_row_end, w_clear, w_adv;

  assign w_abort   = bus.abort && (r_state != ST_IDLE);
  assign w_row_end = (r_row == ROW_W'(ARRAY_SIZE - 1));
  // Kernel position restarts on image start and on each accepted non-final row.
  assign w_clear   = !bus.abort &&
                     (((r_state == ST_IDLE) && bus.start) ||
                      ((r_state == ST_EMIT) && bus.row_ready && !w_row_end));
  assign w_adv     = !bus.abort && (r_state == ST_ISSUE) && bus.tap_ready;

  conv_tap_counter #(.KERNEL_SIZE(KERNEL_SIZE)) u_tap (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_adv    (w_adv),
    .o_kr     (w_kr),
    .o_kc     (w_kc),
    .o_w_addr (w_waddr),
    .o_first  (w_first),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_drain <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start && !bus.abort) begin
          r_row   <= '0;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: if (bus.tap_ready && w_last) begin
          r_drain <= DRAIN_W'(PIPE_LAT - 1);
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (r_drain == '0) r_state <= ST_EMIT;
                  else r_drain <= r_drain - DRAIN_W'(1);
        ST_EMIT: if (bus.row_ready) begin
          if (w_row_end) r_state <= ST_DONE;
          else begin
            r_row   <= r_row + ROW_W'(1);
            r_state <= ST_ISSUE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.tap_valid = (r_state == ST_ISSUE);
  assign bus.tap_first = (r_state == ST_ISSUE) && w_first;
  assign bus.tap_last  = (r_state == ST_ISSUE) && w_last;
  assign bus.pix_row   = PIX_W'(r_row) + PIX_W'(w_kr);
  assign bus.pix_col   = PIX_W'(w_kc);
  assign bus.w_addr    = w_waddr;
  assign bus.row_valid = (r_state == ST_EMIT);
  assign bus.row_idx   = r_row;
endmodule

// File: tb/tb_conv_row_scheduler.sv
// Randomized bench for conv_row_scheduler against an image-level tap/row reference model.
module tb_conv_row_scheduler;
  import conv_sched_pkg::*;

  logic clk = 1'b0;
  logic rst, start, abort, tap_ready, row_ready;
  always #5 clk = ~clk;

  conv_row_scheduler_if b0();
  conv_row_scheduler_if b1();
  assign b0.start = start;  assign b0.abort = abort;
  assign b0.tap_ready = tap_ready;  assign b0.row_ready = row_ready;
  assign b1.start = start;  assign b1.abort = abort;
  assign b1.tap_ready = tap_ready;  assign b1.row_ready = row_ready;

  conv_row_scheduler #(.PIPE_LAT(4)) dut  (.clk(clk), .rst(rst), .bus(b0));
  conv_row_scheduler #(.PIPE_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int sel = 0;
  logic m_busy, m_done, m_tv, m_tf, m_tl, m_rv;
  logic [2:0] m_pr, m_pc, m_ri;
  logic [3:0] m_wa;
  assign m_busy = (sel == 1) ? b1.busy      : b0.busy;
  assign m_done = (sel == 1) ? b1.done      : b0.done;
  assign m_tv   = (sel == 1) ? b1.tap_valid : b0.tap_valid;
  assign m_tf   = (sel == 1) ? b1.tap_first : b0.tap_first;
  assign m_tl   = (sel == 1) ? b1.tap_last  : b0.tap_last;
  assign m_rv   = (sel == 1) ? b1.row_valid : b0.row_valid;
  assign m_pr   = (sel == 1) ? b1.pix_row   : b0.pix_row;
  assign m_pc   = (sel == 1) ? b1.pix_col   : b0.pix_col;
  assign m_ri   = (sel == 1) ? b1.row_idx   : b0.row_idx;
  assign m_wa   = (sel == 1) ? b1.w_addr    : b0.w_addr;

  int n_checks = 0, n_errs = 0;
  int stall_tap, stall_n, stall_row, stall_rn, start_cyc, abort_cyc;
  bit rnd;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic knobs_default;
    stall_tap = -1; stall_n = 0; stall_row = -1; stall_rn = 0;
    start_cyc = -1; abort_cyc = -1; rnd = 0;
  endtask

  // Runs one image from a start pulse; every cycle is compared with the
  // ideal tap sequence (r, kr, kc) and row order derived from tap/row counts.
  task automatic run_img(output int done_cyc, output int row0_cyc);
    int t = 0, e = 0, last_x = 0, st = 0, rs = 0, lat, k;
    bit prev_rv = 0, prev_acc = 0, prev_hold = 0;
    lat = (sel == 1) ? 1 : 4;
    done_cyc = -1; row0_cyc = -1;
    start = 1; tick; start = 0;
    for (int c = 1; c <= 3000; c++) begin
      start = (c == start_cyc);
      abort = (c == abort_cyc);
      tap_ready = 1; row_ready = 1;
      if (rnd) begin
        tap_ready = ($urandom_range(0, 3) != 0);
        row_ready = ($urandom_range(0, 2) != 0);
      end
      if (m_tv && t == stall_tap && st < stall_n) begin tap_ready = 0; st++; end
      if (m_rv && e == stall_row && rs < stall_rn) begin row_ready = 0; rs++; end
      n_checks++;
      if (m_busy !== 1'b1) begin n_errs++; $display("FAIL busy c=%0d got=%b want=1", c, m_busy); end
      n_checks++;
      if (m_tv && m_rv) begin n_errs++; $display("FAIL tap_row_overlap c=%0d got both high want exclusive", c); end
      if (prev_acc) begin
        n_checks++;
        if (m_tv !== 1'b1 || m_tf !== 1'b1) begin
          n_errs++; $display("FAIL first_after_accept c=%0d got tv=%b tf=%b want 1 1", c, m_tv, m_tf);
        end
      end
      if (prev_hold) begin
        n_checks++;
        if (m_rv !== 1'b1 || m_ri !== 3'(e)) begin
          n_errs++; $display("FAIL row_hold c=%0d got rv=%b idx=%0d want 1 %0d", c, m_rv, m_ri, e);
        end
      end
      if (m_tv) begin
        k = t % 9;
        n_checks++;
        if (t >= 54 || m_pr !== 3'(t / 9 + k / 3) || m_pc !== 3'(k % 3) || m_wa !== 4'(k) ||
            m_tf !== (k == 0) || m_tl !== (k == 8)) begin
          n_errs++;
          $display("FAIL tap c=%0d t=%0d got row=%0d col=%0d wa=%0d f=%b l=%b want %0d %0d %0d %b %b",
                   c, t, m_pr, m_pc, m_wa, m_tf, m_tl, t / 9 + k / 3, k % 3, k, k == 0, k == 8);
        end
      end
      if (m_rv) begin
        n_checks++;
        if (m_ri !== 3'(e) || t != 9 * (e + 1)) begin
          n_errs++; $display("FAIL row c=%0d got idx=%0d taps=%0d want %0d %0d", c, m_ri, t, e, 9 * (e + 1));
        end
        if (!prev_rv) begin
          n_checks++;
          if (c - last_x != lat + 1) begin
            n_errs++; $display("FAIL drain_len c=%0d got=%0d want=%0d", c, c - last_x - 1, lat);
          end
          if (e == 0) row0_cyc = c;
        end
      end
      if (m_done) begin
        n_checks++;
        if (e != 6 || t != 54) begin n_errs++; $display("FAIL done_early c=%0d got rows=%0d taps=%0d want 6 54", c, e, t); end
        done_cyc = c;
      end
      if (abort) begin
        tick; abort = 0;
        n_checks++;
        if ({m_busy, m_tv, m_rv, m_done} !== 4'b0) begin
          n_errs++; $display("FAIL abort_idle got b/tv/rv/d=%b want 0000", {m_busy, m_tv, m_rv, m_done});
        end
        for (int i = 0; i < 20; i++) begin
          tick;
          n_checks++;
          if (m_done !== 1'b0 || m_busy !== 1'b0) begin
            n_errs++; $display("FAIL abort_no_done got d=%b b=%b want 0 0", m_done, m_busy);
          end
        end
        break;
      end
      prev_rv   = m_rv;
      prev_hold = m_rv && !row_ready;
      prev_acc  = m_rv && row_ready && e < 5;
      if (m_tv && tap_ready) begin
        if (t % 9 == 8) last_x = c;
        t++;
      end
      if (m_rv && row_ready) e++;
      if (m_done) break;
      tick;
    end
    start = 0; tap_ready = 1; row_ready = 1;
    if (done_cyc >= 0) begin
      tick;
      n_checks++;
      if (m_busy !== 1'b0 || m_done !== 1'b0) begin
        n_errs++; $display("FAIL after_done got b=%b d=%b want 0 0", m_busy, m_done);
      end
    end else if (abort_cyc < 0) begin
      n_errs++; n_checks++; $display("FAIL timeout got no done want done");
    end
    for (int i = 0; i < 200 && (b0.busy || b1.busy); i++) tick;
  endtask

  task automatic test_reset;
    rst = 1; tick; tick; rst = 0;
    n_checks++;
    if ({m_busy, m_done, m_tv, m_rv, m_tf, m_tl} !== 6'b0) begin
      n_errs++; $display("FAIL reset_ctrl got=%b want=000000", {m_busy, m_done, m_tv, m_rv, m_tf, m_tl});
    end
    n_checks++;
    if ({m_pr, m_pc, m_wa, m_ri} !== 13'b0) begin
      n_errs++; $display("FAIL reset_fields got=%h want=0", {m_pr, m_pc, m_wa, m_ri});
    end
    tick;
    n_checks++;
    if (m_busy !== 1'b0) begin n_errs++; $display("FAIL reset_stay_idle got=%b want=0", m_busy); end
  endtask

  task automatic run_expect(input string nm, input int want_done, input int want_r0);
    int d, r0;
    run_img(d, r0);
    n_checks++;
    if (d != want_done || r0 != want_r0) begin
      n_errs++; $display("FAIL %s got done=%0d row0=%0d want %0d %0d", nm, d, r0, want_done, want_r0);
    end
  endtask

  task automatic test_nominal;
    knobs_default; sel = 0;
    run_expect("nominal", 85, 14);
  endtask

  task automatic test_tap_stall;
    knobs_default; sel = 0; stall_tap = 13; stall_n = 3;
    run_expect("tap_stall", 88, 14);
  endtask

  task automatic test_row_stall;
    knobs_default; sel = 0; stall_row = 2; stall_rn = 5;
    run_expect("row_stall", 90, 14);
  endtask

  task automatic test_start_ignored;
    knobs_default; sel = 0; start_cyc = 17;
    run_expect("start_in_issue", 85, 14);
    start = 1; abort = 1; tick; start = 0; abort = 0;
    n_checks++;
    if (m_busy !== 1'b0 || m_tv !== 1'b0) begin
      n_errs++; $display("FAIL start_abort_idle got b=%b tv=%b want 0 0", m_busy, m_tv);
    end
    tick;
    n_checks++;
    if (m_busy !== 1'b0) begin n_errs++; $display("FAIL start_abort_stay got=%b want=0", m_busy); end
  endtask

  task automatic test_abort;
    int d, r0;
    knobs_default; sel = 0; abort_cyc = 53;
    run_img(d, r0);
    n_checks++;
    if (d != -1) begin n_errs++; $display("FAIL abort_done got=%0d want=-1", d); end
    knobs_default;
    run_expect("restart_after_abort", 85, 14);
  endtask

  task automatic test_mid_reset;
    sel = 0;
    start = 1; tick; start = 0;
    repeat (4) tick;
    rst = 1; tick; rst = 0;
    n_checks++;
    if ({m_busy, m_done, m_tv, m_rv, m_tf, m_tl, m_pr, m_pc, m_wa, m_ri} !== 19'b0) begin
      n_errs++;
      $display("FAIL mid_reset got=%h want=0", {m_busy, m_done, m_tv, m_rv, m_tf, m_tl, m_pr, m_pc, m_wa, m_ri});
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      n_checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) begin
        n_errs++; $display("FAIL mid_reset_quiet got d=%b b=%b want 0 0", m_done, m_busy);
      end
    end
  endtask

  task automatic test_pipe_lat1;
    knobs_default; sel = 1;
    run_expect("pipe_lat1", 67, 11);
    sel = 0;
  endtask

  task automatic test_random;
    int d, r0;
    knobs_default; rnd = 1;
    for (int i = 0; i < 4; i++) begin
      sel = i % 2;
      run_img(d, r0);
      n_checks++;
      if (d < ((sel == 1) ? 67 : 85)) begin
        n_errs++; $display("FAIL random_done sel=%0d got=%0d want>=%0d", sel, d, (sel == 1) ? 67 : 85);
      end
    end
    sel = 0; knobs_default;
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; tap_ready = 1; row_ready = 1;
    knobs_default;
    test_reset;
    test_nominal;
    test_tap_stall;
    test_row_stall;
    test_start_ignored;
    test_abort;
    test_mid_reset;
    test_pipe_lat1;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
